// File: rtl/hd_rr_arbiter.sv
// hd_rr_arbiter: round-robin arbiter feeding one registered valid/ready output slot.
// Each accepted beat is tagged with the index of the requester that supplied it.
// Optional build macro HD_ARB_PRIO_EN: lane 0 gets strict priority and the
// round-robin search covers lanes 1..NUM_REQ-1 only.
module hd_rr_arbiter #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REQ    = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]              out_src,
    input  logic                          out_ready,
    output logic                          busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t             state_q;
    slot_state_t             state_d;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_found;
    logic                    accept_en;
    logic                    transfer;
    logic                    ptr_upd;
    logic [DATA_WIDTH-1:0]   lane_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign lane_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign out_valid = (state_q == FULL);
    assign accept_en = !out_valid || out_ready;
    assign transfer  = grant_found && accept_en && rst;
    assign busy      = out_valid || (|req_valid);

    // Grant search: first valid lane starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        ptr_upd     = 1'b0;
`ifdef HD_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!grant_found && (cand != '0) && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
            ptr_upd = grant_found;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_upd = grant_found;
`endif
    end

    // Ready is the one-hot grant, gated by slot availability and reset.
    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Slot next-state: fill on accept, drain when consumed without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (transfer) state_d = FULL;
            FULL: begin
                if (transfer)       state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted beat and advance the round-robin pointer past it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (transfer) begin
            out_data <= lane_data[grant_idx];
            out_src  <= grant_idx;
            if (ptr_upd) begin
                ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hd_rr_arbiter.sv
// tb_hd_rr_arbiter: directed bench for hd_rr_arbiter (NUM_REQ=4, DATA_WIDTH=16).
module tb_hd_rr_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_ready;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hd_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_data(input logic [DW-1:0] base);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = base + DW'(i);
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 4'hF; out_ready = 1'b1; set_data(16'h0A00);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h0000 || out_src !== 2'd0) $display("FAIL reset_slot got %h/%0d exp 0000/0", out_data, out_src); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL release_grant got %b exp %b", req_ready, 4'b0001); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 16'h0A00)
            $display("FAIL release_first_beat got v=%b src=%0d data=%h exp v=1 src=0 data=0a00", out_valid, out_src, out_data);
        else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_src [5];
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset;
        set_data(16'h0A00);
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_src !== exp_src[k] || out_data !== (16'h0A00 + 16'(exp_src[k])))
                $display("FAIL rr_beat%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                         k, out_valid, out_src, out_data, exp_src[k], 16'h0A00 + 16'(exp_src[k]));
            else pass_cnt++;
        end
        req_valid = '0;
    endtask

    task automatic test_stall;
        do_reset;
        req_data  = '0;
        req_data[1*DW +: DW] = 16'h1111;
        req_data[3*DW +: DW] = 16'h3333;
        req_valid = 4'b1010;
        out_ready = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL empty_accept got %b exp %b", req_ready, 4'b0010); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 16'h1111 || req_ready !== 4'b0000)
                $display("FAIL stall%0d got v=%b src=%0d data=%h rdy=%b exp v=1 src=1 data=1111 rdy=0000",
                         k, out_valid, out_src, out_data, req_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL resume_grant got %b exp %b", req_ready, 4'b1000); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_src !== 2'd3 || out_data !== 16'h3333) $display("FAIL resume_b1 got src=%0d data=%h exp src=3 data=3333", out_src, out_data); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_src !== 2'd1 || out_data !== 16'h1111 || out_valid !== 1'b1) $display("FAIL resume_b2 got src=%0d data=%h exp src=1 data=1111", out_src, out_data); else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_single_lane;
        do_reset;
        set_data(16'h2200);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 16'h2202)
                $display("FAIL single%0d got v=%b src=%0d data=%h exp v=1 src=2 data=2202", k, out_valid, out_src, out_data);
            else pass_cnt++;
        end
        req_valid = '0;
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_full got %b exp 1", busy); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL drain got v=%b busy=%b exp v=0 busy=0", out_valid, busy); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        do_reset;
        set_data(16'h0A00);
        req_valid = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) $display("FAIL pre_reset got v=%b src=%0d exp v=1 src=1", out_valid, out_src); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_src !== 2'd0 || req_ready !== 4'b0000)
            $display("FAIL async_reset got v=%b data=%h src=%0d rdy=%b exp v=0 data=0000 src=0 rdy=0000", out_valid, out_data, out_src, req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL post_reset_grant got %b exp %b", req_ready, 4'b0001); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_src !== 2'd0 || out_valid !== 1'b1) $display("FAIL post_reset_beat got v=%b src=%0d exp v=1 src=0", out_valid, out_src); else pass_cnt++;
        req_valid = '0;
    endtask

`ifdef HD_ARB_PRIO_EN
    task automatic test_prio;
        logic [1:0] exp_src [4];
        exp_src = '{2'd1, 2'd2, 2'd3, 2'd1};
        do_reset;
        set_data(16'h0A00);
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_src !== 2'd0 || out_valid !== 1'b1) $display("FAIL prio%0d got src=%0d exp 0", k, out_src); else pass_cnt++;
        end
        req_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_src !== exp_src[k]) $display("FAIL prio_rr%0d got src=%0d exp %0d", k, out_src, exp_src[k]); else pass_cnt++;
        end
        req_valid = '0;
    endtask
`endif

    initial begin
        rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b1;
        test_reset;
`ifndef HD_ARB_PRIO_EN
        test_round_robin;
        test_stall;
        test_single_lane;
        test_mid_reset;
`else
        test_prio;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
